// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared defaults and helpers for the parameterised FIFO.
//
// Contents:
//   DEFAULT_DATA_W  default data word width
//   DEFAULT_DEPTH   default number of entries
//   clog2()         ceiling log2, used to size pointers and the count port
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Returns the smallest r with 2**r >= value.
  // Written as a bounded loop so it also works as a constant function during elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem -- storage array for param_fifo.
// Simple dual-port RAM: one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents survive a FIFO reset.
//
// Ports:
//   clk_i     write clock
//   wrEn_i    write enable
//   wrAddr_i  write address
//   wrData_i  write data
//   rdAddr_i  read address (combinational read)
//   rdData_o  read data
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk_i,
  input  logic              wrEn_i,
  input  logic [AW-1:0]     wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [AW-1:0]     rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] memArray [DEPTH];

  // Write port. The array has no reset, so it maps cleanly onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      memArray[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = memArray[rdAddr_i];

endmodule

// File: rtl/param_fifo.sv
// param_fifo -- single-clock parameterised FIFO with status and sticky error flags.
//
// Parameters:
//   DATA_W     word width
//   DEPTH      entries (power of two, >= 2)
//   AF_THRESH  almost_full asserted when count >= AF_THRESH
//   AE_THRESH  almost_empty asserted when count <= AE_THRESH
//   FWFT       0 = registered read with one-cycle valid pulse, 1 = first-word-fall-through
//
// Ports:
//   clk, rst_n (async active-low)
//   din, wr_en, rd_en, err_clr   inputs
//   dout, valid                  read data and its qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow          sticky error flags, cleared by err_clr
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wrAccept, rdAccept;
  logic [DATA_W-1:0] memRdData;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A read never happens on an empty FIFO; a write into a full FIFO is allowed only
  // when a read frees the slot on the same edge.
  assign rdAccept = rd_en && !empty;
  assign wrAccept = wr_en && (!full || rdAccept);

  assign count        = count_q;
  assign almost_full  = (count_q >= PW'(AF_THRESH));
  assign almost_empty = (count_q <= PW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i    (clk),
    .wrEn_i   (wrAccept),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wrData_i (din),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdData_o (memRdData)
  );

  // Next-state for pointers, count and sticky error flags.
  // An error event in the same cycle as err_clr keeps its flag set.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full && !rdAccept) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown straight from the RAM; zero while empty so reset reads as 0.
      assign dout  = empty ? '0 : memRdData;
      assign valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      // Registered read: capture the head on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rdAccept;
          if (rdAccept) begin
            dout_q <= memRdData;
          end
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo -- directed self-checking bench for param_fifo.
// Main instance: DATA_W=8, DEPTH=8, AF=6, AE=1, FWFT=0. Second instance uses FWFT=1.
module tb_param_fifo;

  logic       clk;
  logic       rstN;
  logic [7:0] din;
  logic       wrEn;
  logic       rdEn;
  logic       errClr;
  logic [7:0] dout;
  logic       valid;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic       almostEmpty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] fDin;
  logic       fWrEn;
  logic       fRdEn;
  logic [7:0] fDout;
  logic       fValid;
  logic       fFull;
  logic       fEmpty;
  logic       fAlmostFull;
  logic       fAlmostEmpty;
  logic [3:0] fCount;
  logic       fOverflow;
  logic       fUnderflow;

  int checkCount;
  int failCount;

  param_fifo #(
    .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .din          (din),
    .wr_en        (wrEn),
    .rd_en        (rdEn),
    .err_clr      (errClr),
    .dout         (dout),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almostFull),
    .almost_empty (almostEmpty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  param_fifo #(
    .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
  ) dutFwft (
    .clk          (clk),
    .rst_n        (rstN),
    .din          (fDin),
    .wr_en        (fWrEn),
    .rd_en        (fRdEn),
    .err_clr      (1'b0),
    .dout         (fDout),
    .valid        (fValid),
    .full         (fFull),
    .empty        (fEmpty),
    .almost_full  (fAlmostFull),
    .almost_empty (fAlmostEmpty),
    .count        (fCount),
    .overflow     (fOverflow),
    .underflow    (fUnderflow)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs from just after a rising edge; returns 1 unit after the next edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d, input logic c);
    wrEn   = w;
    rdEn   = r;
    din    = d;
    errClr = c;
    @(posedge clk);
    #1;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    errClr = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] expWord;
    logic       doRd;

    checkCount = 0;
    failCount  = 0;
    rstN   = 1'b0;
    din    = '0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    errClr = 1'b0;
    fDin   = '0;
    fWrEn  = 1'b0;
    fRdEn  = 1'b0;

    #12 rstN = 1'b1;
    @(posedge clk);
    #1;

    // Reset values
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_afull", almostFull, 0);
    checkOutput("rst_aempty", almostEmpty, 1);
    checkOutput("rst_dout", dout, 8'h00);
    checkOutput("rst_valid", valid, 0);

    // Mid-clock reset discards words and clears outputs without a clock edge
    applyStimulus(1, 0, 8'h3C, 0);
    applyStimulus(1, 0, 8'hC3, 0);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("pre_rst_dout", dout, 8'h3C);
    checkOutput("pre_rst_count", count, 1);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_rst_empty", empty, 1);
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_dout", dout, 8'h00);
    checkOutput("async_rst_valid", valid, 0);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_empty", empty, 1);

    // Fill 0x00..0x07
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'(i), 0);
      checkOutput("fill_count", count, i + 1);
      checkOutput("fill_afull", almostFull, (i + 1) >= 6);
      checkOutput("fill_aempty", almostEmpty, (i + 1) <= 1);
      checkOutput("fill_full", full, i == 7);
    end
    applyStimulus(1, 0, 8'hAA, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", count, 8);
    checkOutput("ovf_full", full, 1);

    // Drain with one-cycle valid pulses
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("drain_dout", dout, i);
      checkOutput("drain_valid", valid, 1);
      checkOutput("drain_count", count, 7 - i);
      applyStimulus(0, 0, 8'h00, 0);
      checkOutput("drain_pulse", valid, 0);
      checkOutput("drain_hold", dout, i);
    end
    checkOutput("drain_ovf_sticky", overflow, 1);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("udf_flag", underflow, 1);
    checkOutput("udf_count", count, 0);
    checkOutput("udf_valid", valid, 0);
    checkOutput("udf_dout", dout, 8'h07);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("clr_ovf", overflow, 0);
    checkOutput("clr_udf", underflow, 0);

    // Full plus simultaneous read/write
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'(8'h80 + i), 0);
    end
    checkOutput("rw_pre_full", full, 1);
    applyStimulus(1, 1, 8'h55, 0);
    checkOutput("rw_dout", dout, 8'h80);
    checkOutput("rw_valid", valid, 1);
    checkOutput("rw_count", count, 8);
    checkOutput("rw_full", full, 1);
    checkOutput("rw_ovf", overflow, 0);
    for (int i = 1; i < 9; i++) begin
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("rw_drain", dout, (i == 8) ? 8'h55 : 8'(8'h80 + i));
      checkOutput("rw_drain_count", count, 8 - i);
    end
    checkOutput("rw_empty", empty, 1);

    // Wrap: 20 writes interleaved with reads, checked against a queue model
    for (int i = 0; i < 20; i++) begin
      doRd = (q.size() >= 3) || ((i % 5 == 4) && (q.size() > 0));
      expWord = 8'h00;
      if (doRd) begin
        expWord = q.pop_front();
      end
      q.push_back(8'(8'h10 + i));
      applyStimulus(1, doRd, 8'(8'h10 + i), 0);
      checkOutput("wrap_valid", valid, doRd);
      if (doRd) begin
        checkOutput("wrap_dout", dout, expWord);
      end
      checkOutput("wrap_count", count, q.size());
    end
    while (q.size() > 0) begin
      expWord = q.pop_front();
      applyStimulus(0, 1, 8'h00, 0);
      checkOutput("wrap_tail", dout, expWord);
    end
    checkOutput("wrap_empty", empty, 1);
    checkOutput("wrap_ovf", overflow, 0);
    checkOutput("wrap_udf", underflow, 0);

    // First-word-fall-through instance
    checkOutput("fwft_init_valid", fValid, 0);
    checkOutput("fwft_init_empty", fEmpty, 1);
    fWrEn = 1'b1;
    fDin  = 8'h5A;
    @(posedge clk);
    #1;
    fWrEn = 1'b0;
    checkOutput("fwft_dout", fDout, 8'h5A);
    checkOutput("fwft_valid", fValid, 1);
    fRdEn = 1'b1;
    @(posedge clk);
    #1;
    fRdEn = 1'b0;
    checkOutput("fwft_pop_empty", fEmpty, 1);
    checkOutput("fwft_pop_valid", fValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, at least 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: count at or above which almost_full is asserted.
REQ-004 SHALL have parameter AE_THRESH, default 2: count at or below which almost_empty is asserted.
REQ-005 SHALL have parameter FWFT, default 0: 0 selects standard read, 1 selects first-word-fall-through.
REQ-006 SHALL have one clock and an active-low reset; reset SHALL be asynchronous.
REQ-007 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 Port rst_n  in  1  asynchronous active-low reset.
REQ-009 Port din  in  DATA_W  write data.
REQ-010 Port wr_en  in  1  write request.
REQ-011 Port rd_en  in  1  read request.
REQ-012 Port err_clr  in  1  clears the sticky error flags.
REQ-013 Port dout  out  DATA_W  read data.
REQ-014 Port valid  out  1  dout holds a valid word.
REQ-015 Port full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 Port count  out  clog2(DEPTH)+1  number of stored words.
REQ-017 Port overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Read and write pointers SHALL be clog2(DEPTH)+1 bits wide and wrap naturally.
- empty: pointers are equal.
- full: MSBs differ and the remaining bits are equal.
REQ-019 A write is accepted when wr_en=1 and either full=0 or a read is accepted in the same cycle.
- An accepted write stores din at the write pointer and increments the write pointer.
REQ-020 A read is accepted when rd_en=1 and empty=0.
- Reading while empty is never accepted, even when a write occurs in the same cycle.
REQ-021 count SHALL update in the same edge as the pointers: +1 write only, -1 read only, unchanged for both or neither.
REQ-022 Flag derivation from registered state; no extra latency relative to count:
- almost_full = (count >= AF_THRESH)
- almost_empty = (count <= AE_THRESH)
REQ-023 When FWFT=0:
- An accepted read SHALL register the head word on dout at the next edge.
- valid SHALL pulse high for that one cycle.
- dout SHALL hold its value otherwise.
REQ-024 When FWFT=1:
- dout SHALL present the head word whenever empty=0, and valid = !empty.
- The first word written into an empty FIFO SHALL appear on dout one cycle after the write edge.
- rd_en pops the word and presents the next one.
REQ-025 overflow SHALL set when wr_en=1 while full=1 and no read is accepted; the write is discarded and state is unchanged.
REQ-026 underflow SHALL set when rd_en=1 while empty=1.
REQ-027 err_clr=1 SHALL clear both sticky flags at the next edge; a new error event in the same cycle SHALL win.
REQ-028 Data order SHALL be strictly first-in first-out across any number of pointer wrap-arounds.

Reset
REQ-029 While rst_n=0, with no clock required, the outputs SHALL be:
- pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0
- dout=0, valid=0, overflow=0, underflow=0
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored words.
REQ-032 Deassertion SHALL take effect at the first following clk edge.

Structure
REQ-033 Package fifo_pkg SHALL hold the default DATA_W/DEPTH values and the clog2 helper used for pointer and count widths.
REQ-034 Storage SHALL be a sub-module fifo_mem: simple dual-port RAM, one synchronous write port and an asynchronous read port, no reset.

Verification
REQ-035 Bench parameters DATA_W=8, DEPTH=8, AF=6, AE=1, FWFT=0, with these scenarios:
- Reset: pulse rst_n low mid-clock -> empty=1, count=0, dout=0x00, valid=0 immediately, no clock edge needed.
- Fill: write 0x00..0x07 -> almost_full after the 6th write, full=1 and count=8 after the 8th; a 9th write of 0xAA -> overflow=1, count=8, 0xAA never read back.
- Drain: 8 reads -> dout 0x00..0x07 in order, each with a one-cycle valid pulse; a 9th read -> underflow=1, count=0; err_clr -> both flags return to 0.
- Full plus simultaneous read/write of 0x55 -> read returns the oldest word, count stays 8, 0x55 is read out last.
- Wrap: 20 interleaved writes 0x10..0x23 with reads -> output sequence identical to input, no flag errors.
- FWFT=1: write 0x5A into an empty FIFO -> dout=0x5A and valid=1 one cycle later; rd_en -> empty=1, valid=0.
